// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-read-port register file.
// Contents: default geometry constants, sweep FSM state type, clog2 helper.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NREAD  = 2;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Address width for n entries; never returns 0 so a 1-entry file still has a legal port.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus interface of reg_file_mp.
// master: drives rd_en, rd_addr, wr_en, wr_addr, wr_data; samples rd_data, busy.
// slave : the register file itself.
interface reg_file_mp_if #(
  parameter int unsigned DATA_W = reg_file_pkg::DEF_DATA_W,
  parameter int unsigned DEPTH  = reg_file_pkg::DEF_DEPTH,
  parameter int unsigned NREAD  = reg_file_pkg::DEF_NREAD
) ();

  localparam int unsigned AW = reg_file_pkg::clog2(DEPTH);

  logic                    rd_en;
  logic [NREAD*AW-1:0]     rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, busy
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One registered read port of reg_file_mp.
// Ports: clk, rst (sync, active-high), clr (hold output at 0 during the clear sweep),
//        rd_en (capture/hold), rd_addr, mem_data (storage word at rd_addr),
//        wr_en/wr_addr/wr_data (same-cycle write for bypass), rd_data (registered).
module reg_file_rd_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic              force_zero_c;
  logic              bypass_hit_c;
  logic [DATA_W-1:0] rd_next_c;

  // Source select: zero/out-of-range beats bypass, bypass beats the stored word.
  always_comb begin
    force_zero_c = 1'b0;
    bypass_hit_c = 1'b0;
    rd_next_c    = mem_data;
    if ((ZERO_REG && (rd_addr == '0)) || !({1'b0, rd_addr} < DEPTH_W)) begin
      force_zero_c = 1'b1;
    end
    if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
      bypass_hit_c = 1'b1;
    end
    if (force_zero_c) begin
      rd_next_c = '0;
    end else if (bypass_hit_c) begin
      rd_next_c = wr_data;
    end
  end

  // Output register: cleared by reset or sweep, held when rd_en is low.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_next_c;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with zero register, optional
// write-to-read bypass, read stall and a post-reset clear sweep.
// Ports: clk, rst (sync, active-high), bus (reg_file_mp_if.slave: rd_en, rd_addr,
//        rd_data, wr_en, wr_addr, wr_data, busy).
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NREAD    = DEF_NREAD,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);

  localparam int unsigned AW       = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  // Storage has no reset so it can map onto RAM; the sweep zeroes it instead.
  logic [DATA_W-1:0] mem [DEPTH];

  state_e        state;
  logic [AW-1:0] ptr;
  logic          busy_q;
  logic          wr_ok_c;

  // A write lands only in READY, never on entry 0 (when hardwired) or past the end.
  always_comb begin
    wr_ok_c = 1'b0;
    if ((state == READY) && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W) &&
        !(ZERO_REG && (bus.wr_addr == '0))) begin
      wr_ok_c = 1'b1;
    end
  end

  // Clear sweep FSM and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      ptr    <= '0;
      busy_q <= 1'b1;
    end else if (state == INIT) begin
      ptr <= ptr + AW'(1);
      if (ptr == LAST_PTR) begin
        state  <= READY;
        busy_q <= 1'b0;
      end
    end
  end

  // Single storage write port shared by sweep and normal writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[ptr] <= '0;
      end else if (wr_ok_c) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  assign bus.busy = busy_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]     addr_c;
    logic [DATA_W-1:0] port_q;

    assign addr_c = bus.rd_addr[i*AW +: AW];

    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .AW       (AW),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .clr      (busy_q),
      .rd_en    (bus.rd_en),
      .rd_addr  (addr_c),
      .mem_data (mem[addr_c]),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .rd_data  (port_q)
    );

    assign bus.rd_data[i*DATA_W +: DATA_W] = port_q;
  end

endmodule
